// File: rtl/csr_irq_file.sv
// csr_irq_file: machine-mode CSR file with interrupt synchronisation,
// fixed-priority interrupt arbitration, vectored trap-target generation,
// trap/MRET status handling and mscratch.
// Optional 64-bit mcycle/minstret counters are compiled in when the
// macro CSR_COUNTERS_EN is defined; without it those addresses decode as
// unknown CSRs.
module csr_irq_file #(
  parameter int unsigned NUM_PLAT_IRQ = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
  parameter logic [31:0] HART_ID      = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    csr_we,
  input  logic                    csr_re,
  input  logic [11:0]             csr_addr,
  input  logic [1:0]              csr_op,
  input  logic [31:0]             csr_wdata,
  output logic [31:0]             csr_rdata,
  output logic                    csr_illegal,
  input  logic                    trap_taken,
  input  logic [31:0]             trap_cause,
  input  logic [31:0]             trap_pc,
  input  logic                    mret_taken,
  input  logic                    instr_retire,
  input  logic                    ext_irq,
  input  logic                    timer_irq,
  input  logic [NUM_PLAT_IRQ-1:0] plat_irq,
  output logic                    irq_req,
  output logic [31:0]             irq_cause,
  output logic [31:0]             trap_target,
  output logic [31:0]             mepc_out,
  output logic                    global_int_enable
);

  // CSR addresses
  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
`endif

  // csr_op encodings
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  // Interrupt line bundle: bit 0 timer, bit 1 external, bits 2.. platform
  localparam int unsigned NI = NUM_PLAT_IRQ + 2;

  // Writable bits of mie: MTIE, MEIE and the platform enables
  localparam logic [31:0] PLAT_MASK = ((32'h1 << NUM_PLAT_IRQ) - 32'h1) << 16;
  localparam logic [31:0] MIE_MASK  = 32'h0000_0880 | PLAT_MASK;

  // Architectural state
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mip_q, mip_d;
  logic [31:0] mscratch_q, mscratch_d;

  // Interrupt synchroniser chain, one vector per stage
  logic [NI-1:0] irq_raw;
  logic [NI-1:0] sync_q [SYNC_STAGES];
  logic [NI-1:0] irq_synced;

  // Access decode
  logic        wr_req;
  logic        access;
  logic        addr_known;
  logic [31:0] rd_val;
  logic [31:0] wval;
  logic        wr_ok;
  logic        wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;

  // Arbitration
  logic [4:0]  win_code;

  // ------------------------------------------------------------------
  // Interrupt input synchronisation
  // ------------------------------------------------------------------
  assign irq_raw    = {plat_irq, ext_irq, timer_irq};
  assign irq_synced = sync_q[SYNC_STAGES-1];

  // Shift raw interrupt levels through SYNC_STAGES flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= irq_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Map synchronised lines onto their mip bit positions
  always_comb begin
    mip_d     = '0;
    mip_d[7]  = irq_synced[0];
    mip_d[11] = irq_synced[1];
    mip_d[16 +: NUM_PLAT_IRQ] = irq_synced[NI-1:2];
  end

  // ------------------------------------------------------------------
  // Address decode and old-value read mux
  // ------------------------------------------------------------------
  assign wr_req = csr_we && (csr_op != 2'b00);
  assign access = csr_we || csr_re;

  // Select the current (pre-write) value of the addressed CSR
  always_comb begin
    addr_known = 1'b1;
    rd_val     = '0;
    case (csr_addr)
      ADDR_MSTATUS:  rd_val = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
      ADDR_MIE:      rd_val = mie_q;
      ADDR_MTVEC:    rd_val = mtvec_q;
      ADDR_MSCRATCH: rd_val = mscratch_q;
      ADDR_MEPC:     rd_val = mepc_q;
      ADDR_MCAUSE:   rd_val = mcause_q;
      ADDR_MIP:      rd_val = mip_q;
      ADDR_MHARTID:  rd_val = HART_ID;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE:    rd_val = g_cnt[0].cnt_q[31:0];
      ADDR_MCYCLEH:   rd_val = g_cnt[0].cnt_q[63:32];
      ADDR_MINSTRET:  rd_val = g_cnt[1].cnt_q[31:0];
      ADDR_MINSTRETH: rd_val = g_cnt[1].cnt_q[63:32];
`endif
      default:       addr_known = 1'b0;
    endcase
  end

  // Unknown addresses are illegal on any access; mhartid is the only
  // known read-only CSR, so a real write to it is illegal too.
  assign csr_illegal = (access && !addr_known) ||
                       (wr_req && (csr_addr == ADDR_MHARTID));

  assign csr_rdata = (csr_re && !csr_illegal) ? rd_val : 32'h0;

  // Apply the read-modify-write operation to the old value
  always_comb begin
    case (csr_op)
      OP_RW:   wval = csr_wdata;
      OP_RS:   wval = rd_val | csr_wdata;
      OP_RC:   wval = rd_val & ~csr_wdata;
      default: wval = rd_val;
    endcase
  end

  assign wr_ok       = wr_req && !csr_illegal;
  assign wr_mstatus  = wr_ok && (csr_addr == ADDR_MSTATUS);
  assign wr_mie      = wr_ok && (csr_addr == ADDR_MIE);
  assign wr_mtvec    = wr_ok && (csr_addr == ADDR_MTVEC);
  assign wr_mscratch = wr_ok && (csr_addr == ADDR_MSCRATCH);
  assign wr_mepc     = wr_ok && (csr_addr == ADDR_MEPC);
  assign wr_mcause   = wr_ok && (csr_addr == ADDR_MCAUSE);

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------

  // mstatus: trap entry beats MRET beats a software write
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    if (trap_taken) begin
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_taken) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (wr_mstatus) begin
      mstatus_mie_d  = wval[3];
      mstatus_mpie_d = wval[7];
    end
  end

  // mepc/mcause: trap entry wins over a same-cycle software write;
  // mepc is always kept word aligned.
  always_comb begin
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (trap_taken) begin
      mepc_d   = trap_pc & ~32'h3;
      mcause_d = trap_cause;
    end else begin
      if (wr_mepc) begin
        mepc_d = wval & ~32'h3;
      end
      if (wr_mcause) begin
        mcause_d = wval;
      end
    end
  end

  // Registers only reachable through software writes
  always_comb begin
    mie_d      = wr_mie ? (wval & MIE_MASK) : mie_q;
    mscratch_d = wr_mscratch ? wval : mscratch_q;
    mtvec_d    = mtvec_q;
    if (wr_mtvec) begin
      // MODE 2/3 are reserved and collapse to direct mode
      mtvec_d = {wval[31:2], 1'b0, wval[0] & ~wval[1]};
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mtvec_q        <= {MTVEC_RESET[31:2], 1'b0, MTVEC_RESET[0] & ~MTVEC_RESET[1]};
      mepc_q         <= '0;
      mcause_q       <= '0;
      mie_q          <= '0;
      mip_q          <= '0;
      mscratch_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mie_q          <= mie_d;
      mip_q          <= mip_d;
      mscratch_q     <= mscratch_d;
    end
  end

  // ------------------------------------------------------------------
  // Optional 64-bit counters: index 0 = mcycle, index 1 = minstret
  // ------------------------------------------------------------------
`ifdef CSR_COUNTERS_EN
  logic [1:0] cnt_inc;
  assign cnt_inc = {instr_retire, 1'b1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    localparam logic [11:0] LO_ADDR = (gi == 0) ? ADDR_MCYCLE : ADDR_MINSTRET;
    localparam logic [11:0] HI_ADDR = (gi == 0) ? ADDR_MCYCLEH : ADDR_MINSTRETH;
    logic [63:0] cnt_q, cnt_d;
    logic        wr_lo, wr_hi;

    assign wr_lo = wr_ok && (csr_addr == LO_ADDR);
    assign wr_hi = wr_ok && (csr_addr == HI_ADDR);

    // A half-write replaces that half and skips this cycle's increment
    always_comb begin
      cnt_d = cnt_q;
      if (wr_lo) begin
        cnt_d[31:0] = wval;
      end else if (wr_hi) begin
        cnt_d[63:32] = wval;
      end else if (cnt_inc[gi]) begin
        cnt_d = cnt_q + 64'd1;
      end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end
`endif

  // ------------------------------------------------------------------
  // Interrupt arbitration and trap target
  // ------------------------------------------------------------------

  // Fixed priority: MEI > MTI > plat[0] > ... > plat[N-1]; scan from the
  // lowest priority upward so the highest pending source wins.
  always_comb begin
    win_code = 5'd0;
    for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
      if (mip_q[16+i] && mie_q[16+i]) begin
        win_code = 5'(16 + i);
      end
    end
    if (mip_q[7] && mie_q[7]) begin
      win_code = 5'd7;
    end
    if (mip_q[11] && mie_q[11]) begin
      win_code = 5'd11;
    end
  end

  assign irq_req   = mstatus_mie_q && (|(mip_q & mie_q));
  assign irq_cause = irq_req ? {1'b1, 26'b0, win_code} : 32'h0;

  // Vectored mode only applies to interrupts; everything else goes to BASE
  always_comb begin
    if ((mtvec_q[1:0] == 2'b01) && trap_cause[31]) begin
      trap_target = {mtvec_q[31:2], 2'b00} + {trap_cause[29:0], 2'b00};
    end else begin
      trap_target = {mtvec_q[31:2], 2'b00};
    end
  end

  assign mepc_out          = mepc_q;
  assign global_int_enable = mstatus_mie_q;

endmodule
